// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Purpose : Shared bus widths, the decoded EXE->MEM bus layout and a small
//           sign-extension helper used by the MEM pipeline stage.
// Contents: EXE_TO_MEM_BUS_WD / MEM_TO_WB_BUS_WD / MEM_TO_BY_BUS_WD widths,
//           exe_to_mem_t (packed, MSB->LSB matches the upstream bus),
//           byte-enable one-hot codes, sext8().
// -----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int EXE_TO_MEM_BUS_WD = 79;
  localparam int MEM_TO_WB_BUS_WD  = 70;
  localparam int MEM_TO_BY_BUS_WD  = 40;

  // Field order is MSB first, so a plain cast of the 79-bit bus unpacks it.
  typedef struct packed {
    logic [2:0]  sel_rf_w_data_valid_stage;
    logic        sel_rf_w_en;
    logic        sel_rf_w_data;
    logic        sel_data_ram_wd;
    logic [3:0]  data_ram_b_en;
    logic [4:0]  rf_w_addr;
    logic [31:0] alu_result;
    logic [31:0] inst_pc;
  } exe_to_mem_t;

  localparam logic [3:0] BEN_BYTE0 = 4'b0001;
  localparam logic [3:0] BEN_BYTE1 = 4'b0010;
  localparam logic [3:0] BEN_BYTE2 = 4'b0100;
  localparam logic [3:0] BEN_BYTE3 = 4'b1000;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Purpose : Combinational load alignment. Picks one byte of the read word via
//           a one-hot byte enable and sign-extends it, or passes the full word.
// Ports   : word     in  32  raw load word
//           b_en     in  4   one-hot byte enable
//           byte_sel in  1   1 = byte load, 0 = word load
//           data     out 32  aligned load result
// -----------------------------------------------------------------------------
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  b_en,
  input  logic        byte_sel,
  output logic [31:0] data
);

  logic [7:0] byte_val;

  always_comb begin
    byte_val = 8'h00;
    case (b_en)
      BEN_BYTE0: byte_val = word[7:0];
      BEN_BYTE1: byte_val = word[15:8];
      BEN_BYTE2: byte_val = word[23:16];
      BEN_BYTE3: byte_val = word[31:24];
      default:   byte_val = 8'h00;  // non one-hot enable: no defined byte
    endcase
    data = byte_sel ? sext8(byte_val) : word;
  end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Purpose : MEM pipeline stage. Registers the EXE->MEM bus, selects load data
//           (from the synchronous Data RAM or a held copy during stalls),
//           and forwards results to WB and to the bypass network.
// Ports   : clk, reset (sync, active-high)
//           EXE_to_MEM_bus[79], EXE_to_MEM_valid  in   upstream payload/valid
//           MEM_allow_in                           out  stage can accept
//           data_ram_r_data[32]                    in   RAM read data (1-cycle)
//           MEM_to_WB_bus[70], MEM_to_WB_valid     out  downstream payload/valid
//           WB_allow_in                            in   downstream ready
//           MEM_to_BY_bus[40]                      out  bypass information
//           perf_load_cnt[32], perf_stall_cnt[32]  out  performance counters
// Config  : MEM_PERF_CNT_EN defined -> counters implemented; otherwise the
//           counter ports are tied to zero.
// -----------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
  input  logic                         EXE_to_MEM_valid,
  output logic                         MEM_allow_in,
  input  logic [31:0]                  data_ram_r_data,
  output logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus,
  output logic                         MEM_to_WB_valid,
  input  logic                         WB_allow_in,
  output logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus,
  output logic [31:0]                  perf_load_cnt,
  output logic [31:0]                  perf_stall_cnt
);

  logic                         mem_valid_reg;
  logic [EXE_TO_MEM_BUS_WD-1:0] bus_reg;
  logic                         rdata_held_reg;
  logic [31:0]                  rdata_buf_reg;

  exe_to_mem_t bus;
  logic        accept;
  logic [31:0] load_src;
  logic [31:0] load_data;
  logic [31:0] rf_w_data;
  logic        sel_valid;

  assign bus          = exe_to_mem_t'(bus_reg);
  assign MEM_allow_in = ~mem_valid_reg | WB_allow_in;  // ready_go is always 1
  assign accept       = EXE_to_MEM_valid & MEM_allow_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_reg  <= 1'b0;
      bus_reg        <= '0;
      rdata_held_reg <= 1'b0;
      rdata_buf_reg  <= '0;
    end else begin
      if (MEM_allow_in)
        mem_valid_reg <= EXE_to_MEM_valid;
      if (accept)
        bus_reg <= EXE_to_MEM_bus;
      // RAM data is only valid in the first cycle after acceptance; snapshot
      // it then so a stall of any length keeps returning the same value.
      if (!rdata_held_reg)
        rdata_buf_reg <= data_ram_r_data;
      rdata_held_reg <= ~accept;
    end
  end

  assign load_src = rdata_held_reg ? rdata_buf_reg : data_ram_r_data;

  mem_load_align u_align (
    .word     (load_src),
    .b_en     (bus.data_ram_b_en),
    .byte_sel (bus.sel_data_ram_wd),
    .data     (load_data)
  );

  assign rf_w_data       = bus.sel_rf_w_data ? load_data : bus.alu_result;
  assign sel_valid       = mem_valid_reg & bus.sel_rf_w_data_valid_stage[1];
  assign MEM_to_WB_valid = mem_valid_reg;
  assign MEM_to_WB_bus   = {bus.sel_rf_w_en, bus.rf_w_addr, rf_w_data, bus.inst_pc};
  assign MEM_to_BY_bus   = {bus.rf_w_addr, rf_w_data, sel_valid, mem_valid_reg,
                            bus.sel_rf_w_en};

  // Only stage bit 1 matters in MEM; the other stage bits belong to other stages.
  logic unused_stage_bits;
  assign unused_stage_bits = &{1'b0, bus.sel_rf_w_data_valid_stage[2],
                               bus.sel_rf_w_data_valid_stage[0]};

`ifdef MEM_PERF_CNT_EN
  logic [31:0] load_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (mem_valid_reg & WB_allow_in & bus.sel_rf_w_data)
        load_cnt_reg <= load_cnt_reg + 32'd1;
      if (mem_valid_reg & ~WB_allow_in)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign perf_load_cnt  = load_cnt_reg;
  assign perf_stall_cnt = stall_cnt_reg;
`else
  assign perf_load_cnt  = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Purpose : Directed self-checking bench for mem_stage. Inputs change 1 ns
//           after a rising edge and outputs are checked at that same point,
//           well away from the next active edge. Counter expectations follow
//           MEM_PERF_CNT_EN (zero when the macro is undefined).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus;
  logic                         EXE_to_MEM_valid;
  logic                         MEM_allow_in;
  logic [31:0]                  data_ram_r_data;
  logic [MEM_TO_WB_BUS_WD-1:0]  MEM_to_WB_bus;
  logic                         MEM_to_WB_valid;
  logic                         WB_allow_in;
  logic [MEM_TO_BY_BUS_WD-1:0]  MEM_to_BY_bus;
  logic [31:0]                  perf_load_cnt;
  logic [31:0]                  perf_stall_cnt;

  int errors = 0;
  int checks = 0;
  int exp_load = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .EXE_to_MEM_bus   (EXE_to_MEM_bus),
    .EXE_to_MEM_valid (EXE_to_MEM_valid),
    .MEM_allow_in     (MEM_allow_in),
    .data_ram_r_data  (data_ram_r_data),
    .MEM_to_WB_bus    (MEM_to_WB_bus),
    .MEM_to_WB_valid  (MEM_to_WB_valid),
    .WB_allow_in      (WB_allow_in),
    .MEM_to_BY_bus    (MEM_to_BY_bus),
    .perf_load_cnt    (perf_load_cnt),
    .perf_stall_cnt   (perf_stall_cnt)
  );

  function automatic logic [78:0] mk_bus(input logic [2:0] stage, input logic wen,
                                         input logic seld, input logic wd,
                                         input logic [3:0] ben, input logic [4:0] wa,
                                         input logic [31:0] alu, input logic [31:0] pc);
    return {stage, wen, seld, wd, ben, wa, alu, pc};
  endfunction

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
`ifdef MEM_PERF_CNT_EN
    check({tag, "_ld"}, 70'(perf_load_cnt), 70'(exp_load));
    check({tag, "_st"}, 70'(perf_stall_cnt), 70'(exp_stall));
`else
    check({tag, "_ld"}, 70'(perf_load_cnt), 70'd0);
    check({tag, "_st"}, 70'(perf_stall_cnt), 70'd0);
`endif
  endtask

  initial begin
    reset = 1'b1; EXE_to_MEM_valid = 1'b0; EXE_to_MEM_bus = '0;
    data_ram_r_data = '0; WB_allow_in = 1'b1;
    step(); step();
    check("rst_valid", 70'(MEM_to_WB_valid), 70'd0);
    check("rst_allow", 70'(MEM_allow_in), 70'd1);
    check("rst_by", 70'(MEM_to_BY_bus), 70'd0);
    check("rst_wb", MEM_to_WB_bus, 70'd0);
    check_cnt("rst_cnt");
    reset = 1'b0;

    // Word load: wen=1, addr 3, pc 0x1000, stage[1]=1
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, 1'b1, 1'b0, 4'b1111, 5'd3, 32'h100, 32'h1000);
    step();
    EXE_to_MEM_valid = 1'b0; data_ram_r_data = 32'h12345678;
    #1;
    check("word_valid", 70'(MEM_to_WB_valid), 70'd1);
    check("word_wb", MEM_to_WB_bus, {1'b1, 5'd3, 32'h12345678, 32'h1000});
    check("word_by", 70'(MEM_to_BY_bus), 70'({5'd3, 32'h12345678, 1'b1, 1'b1, 1'b1}));
    step(); exp_load++;
    check("drain_valid", 70'(MEM_to_WB_valid), 70'd0);

    // Byte loads, back to back
    EXE_to_MEM_valid = 1'b1;
    EXE_to_MEM_bus = mk_bus(3'b000, 1'b1, 1'b1, 1'b1, 4'b0100, 5'd4, 32'h0, 32'h2000);
    step();
    data_ram_r_data = 32'h00800000;
    EXE_to_MEM_bus = mk_bus(3'b000, 1'b1, 1'b1, 1'b1, 4'b0001, 5'd5, 32'h0, 32'h2004);
    #1;
    check("byte2_neg", 70'(MEM_to_WB_bus[63:32]), 70'(32'hFFFFFF80));
    step(); exp_load++;
    data_ram_r_data = 32'h0000007F;
    EXE_to_MEM_bus = mk_bus(3'b000, 1'b1, 1'b1, 1'b1, 4'b0010, 5'd6, 32'h0, 32'h2008);
    #1;
    check("byte0_pos", 70'(MEM_to_WB_bus[63:32]), 70'(32'h0000007F));
    step(); exp_load++;
    EXE_to_MEM_valid = 1'b0; data_ram_r_data = 32'h0000FE00;
    #1;
    check("byte1_neg", MEM_to_WB_bus, {1'b1, 5'd6, 32'hFFFFFFFE, 32'h2008});
    step(); exp_load++;

    // Stall: load accepted while WB is blocked for 3 cycles
    EXE_to_MEM_valid = 1'b1; WB_allow_in = 1'b0;
    EXE_to_MEM_bus = mk_bus(3'b000, 1'b1, 1'b1, 1'b0, 4'b1111, 5'd7, 32'h0, 32'h3000);
    step();
    data_ram_r_data = 32'hCAFEF00D;
    EXE_to_MEM_bus = mk_bus(3'b010, 1'b0, 1'b0, 1'b0, 4'b0000, 5'd9, 32'h55, 32'h3004);
    #1;
    check("stall_allow", 70'(MEM_allow_in), 70'd0);
    check("stall_d0", 70'(MEM_to_WB_bus[63:32]), 70'(32'hCAFEF00D));
    check("stall_by", 70'(MEM_to_BY_bus[2:0]), 70'(3'b011));
    step(); exp_stall++;
    data_ram_r_data = 32'hDEADBEEF;
    #1;
    check("stall_d1", MEM_to_WB_bus, {1'b1, 5'd7, 32'hCAFEF00D, 32'h3000});
    step(); exp_stall++;
    check("stall_d2", 70'(MEM_to_WB_bus[63:32]), 70'(32'hCAFEF00D));
    step(); exp_stall++;
    check_cnt("stall_cnt");
    EXE_to_MEM_valid = 1'b0; WB_allow_in = 1'b1;
    #1;
    check("stall_rel", 70'({MEM_allow_in, MEM_to_WB_valid}), 70'(2'b11));
    check("stall_d3", 70'(MEM_to_WB_bus[63:32]), 70'(32'hCAFEF00D));
    step(); exp_load++;
    check("stall_drain", 70'(MEM_to_WB_valid), 70'd0);
    check_cnt("after_stall");

    // Back-to-back ALU ops 1,2,3; stage[1] = 1,0,1
    EXE_to_MEM_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      EXE_to_MEM_bus = mk_bus((i == 2) ? 3'b000 : 3'b010, 1'b1, 1'b0, 1'b0, 4'b0000,
                              5'(i + 10), 32'(i), 32'h4000 + 32'(4 * i));
      step();
      data_ram_r_data = 32'hFFFF0000;
      check($sformatf("alu%0d_wb", i), {MEM_to_WB_valid, MEM_to_WB_bus[63:32]},
            70'({1'b1, 32'(i)}));
      check($sformatf("alu%0d_by", i), 70'(MEM_to_BY_bus[2:1]),
            70'((i == 2) ? 2'b01 : 2'b11));
    end
    EXE_to_MEM_valid = 1'b0;
    EXE_to_MEM_bus = mk_bus(3'b111, 1'b0, 1'b1, 1'b1, 4'b1000, 5'd31, 32'h99, 32'h9999);
    step();
    check("alu_drain_v", 70'(MEM_to_WB_valid), 70'd0);
    check("alu_drain_bus", MEM_to_WB_bus, {1'b1, 5'd13, 32'd3, 32'h400C});
    check("alu_drain_by", 70'(MEM_to_BY_bus[2:1]), 70'd0);

    // Reset during a stall
    EXE_to_MEM_valid = 1'b1; WB_allow_in = 1'b0;
    EXE_to_MEM_bus = mk_bus(3'b010, 1'b1, 1'b1, 1'b0, 4'b1111, 5'd8, 32'h0, 32'h5000);
    step();
    EXE_to_MEM_valid = 1'b0;
    check("rs_stall", 70'({MEM_to_WB_valid, MEM_allow_in}), 70'(2'b10));
    step(); exp_stall++;
    check_cnt("rs_pre");
    reset = 1'b1;
    step();
    exp_load = 0; exp_stall = 0;
    check("rs_valid", 70'(MEM_to_WB_valid), 70'd0);
    check("rs_allow", 70'(MEM_allow_in), 70'd1);
    check("rs_by", 70'(MEM_to_BY_bus), 70'd0);
    check_cnt("rs_cnt");
    reset = 1'b0;
    step();
    check("post_rs_valid", 70'(MEM_to_WB_valid), 70'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
